// File: rtl/otp_tx_serializer.sv
// Buffers OTP core result words and sends each as a UART-style frame: start, 16 data bits LSB first, [parity], stop.
// Define OTP_TX_PARITY_EN to add an even-parity bit after the data bits (19-bit frame instead of 18).
module otp_tx_serializer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [15:0]                   word_in,
    input  logic                          word_done,
    input  logic                          clear_overflow,
    output logic                          tx_serial,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef OTP_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_e;

    state_e        state_q, state_d;
    logic          s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic [15:0]   shift_q, shift_d;
    logic          tx_q, tx_d;
    logic [15:0]   mem_q [FIFO_DEPTH];
`ifdef OTP_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    logic push, pop, full, push_ok, bit_tick;

    // One push per rising edge of the synchronized word_done level.
    always_comb begin
        s1_d     = word_done;
        s2_d     = s1_q;
        s3_d     = s2_q;
        push     = s2_q & ~s3_q;
        pop      = (state_q == S_IDLE) && (count_q != '0);
        full     = (count_q == FULL_COUNT);
        push_ok  = push && (!full || pop);
        bit_tick = (cnt_q == CNT_LAST);
    end

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
        overflow_d = overflow_q;
        if (clear_overflow) overflow_d = 1'b0;
        if (push && full && !pop) overflow_d = 1'b1;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (pop) state_d = S_START;
            S_START:  if (bit_tick) state_d = S_DATA;
`ifdef OTP_TX_PARITY_EN
            S_DATA:   if (bit_tick && bit_idx_q == 4'd15) state_d = S_PARITY;
            S_PARITY: if (bit_tick) state_d = S_STOP;
`else
            S_DATA:   if (bit_tick && bit_idx_q == 4'd15) state_d = S_STOP;
`endif
            S_STOP:   if (bit_tick) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (state_q == S_IDLE || state_d != state_q || bit_tick) cnt_d = '0;
        bit_idx_d = bit_idx_q;
        if (state_q == S_IDLE) bit_idx_d = 4'd0;
        else if (state_q == S_DATA && bit_tick) bit_idx_d = bit_idx_q + 4'd1;
        shift_d = shift_q;
        if (pop) shift_d = mem_q[rd_ptr_q];
        else if (state_q == S_DATA && bit_tick) shift_d = shift_q >> 1;
`ifdef OTP_TX_PARITY_EN
        parity_d = pop ? ^mem_q[rd_ptr_q] : parity_q;
`endif
    end

    // NOTE: tx_d decodes the next state so the registered line changes on the same edge as the state.
    always_comb begin
        tx_busy = (state_q != S_IDLE);
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef OTP_TX_PARITY_EN
            S_PARITY: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            cnt_q      <= '0;
            bit_idx_q  <= 4'd0;
            shift_q    <= 16'd0;
            tx_q       <= 1'b1;
`ifdef OTP_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
`ifdef OTP_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // NOTE: storage is not reset; count_q alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= word_in;
    end

    assign tx_serial  = tx_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_otp_tx_serializer.sv
// Directed bench for otp_tx_serializer with CLKS_PER_BIT=4, FIFO_DEPTH=4; follows OTP_TX_PARITY_EN if defined.
module tb_otp_tx_serializer;

    localparam int N = 4;
`ifdef OTP_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int F = 18 + P;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] word_in = 16'd0;
    logic        word_done = 1'b0;
    logic        clear_overflow = 1'b0;
    logic        tx_serial, tx_busy, overflow;
    logic [2:0]  fifo_count;

    int total = 0;
    int bad   = 0;

    otp_tx_serializer #(.CLKS_PER_BIT(N), .FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .word_in        (word_in),
        .word_done      (word_done),
        .clear_overflow (clear_overflow),
        .tx_serial      (tx_serial),
        .tx_busy        (tx_busy),
        .fifo_count     (fifo_count),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        word_done = 1'b0;
        clear_overflow = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Call at the negedge inside the first start-bit cycle; returns at the idle cycle after the stop bit.
    task automatic check_frame(input logic [15:0] w, input logic par, input string tag);
        logic       exp_bits [19];
        logic [1:0] obs;
        int         busy_n;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 16; i++) exp_bits[i + 1] = w[i];
        exp_bits[17] = par;
        exp_bits[18] = 1'b1;
        exp_bits[F - 1] = 1'b1;
        busy_n = 0;
        obs = 2'b00;
        for (int b = 0; b < F; b++) begin
            for (int c = 0; c < N; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (c == 0) obs = {1'b0, tx_serial};
                else if (tx_serial !== obs[0]) obs = 2'b10;
                if (tx_busy === 1'b1) busy_n++;
            end
            check($sformatf("%s_bit%0d", tag, b), 32'(obs), 32'(exp_bits[b]));
        end
        check({tag, "_busy_cycles"}, busy_n, F * N);
        @(negedge clk);
        check({tag, "_idle_tx"}, 32'(tx_serial), 32'd1);
        check({tag, "_idle_busy"}, 32'(tx_busy), 32'd0);
    endtask

    task automatic send_and_check(input logic [15:0] w, input logic par, input string tag);
        word_in = w;
        word_done = 1'b1;
        repeat (3) @(negedge clk);
        word_done = 1'b0;
        @(negedge clk);
        check({tag, "_start"}, 32'(tx_serial), 32'd0);
        check_frame(w, par, tag);
    endtask

    task automatic push_fast(input logic [15:0] w);
        word_in = w;
        word_done = 1'b1;
        repeat (2) @(negedge clk);
        word_done = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int lows;

        // Reset state and quiet line.
        do_reset();
        check("rst_tx", 32'(tx_serial), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_serial !== 1'b1 || tx_busy !== 1'b0) lows++;
        end
        check("idle_100", lows, 0);

        // Single word with exact capture and start latency.
        do_reset();
        word_in = 16'h2733;
        word_done = 1'b1;
        @(negedge clk);
        check("lat_k_count", 32'(fifo_count), 32'd0);
        @(negedge clk);
        check("lat_k1_count", 32'(fifo_count), 32'd0);
        @(negedge clk);
        check("lat_k2_count", 32'(fifo_count), 32'd1);
        check("lat_k2_tx", 32'(tx_serial), 32'd1);
        check("lat_k2_busy", 32'(tx_busy), 32'd0);
        word_done = 1'b0;
        @(negedge clk);
        check("lat_k3_tx", 32'(tx_serial), 32'd0);
        check("lat_k3_busy", 32'(tx_busy), 32'd1);
        check("lat_k3_count", 32'(fifo_count), 32'd0);
        check_frame(16'h2733, 1'b0, "w2733");

        // Parity values.
        send_and_check(16'hDEAD, 1'b1, "wdead");
        send_and_check(16'h0001, 1'b1, "w0001");

        // Back-to-back frames.
        do_reset();
        word_in = 16'h2733;
        word_done = 1'b1;
        repeat (3) @(negedge clk);
        check("b2b_cnt_a1", 32'(fifo_count), 32'd1);
        word_done = 1'b0;
        @(negedge clk);
        check("b2b_cnt_a0", 32'(fifo_count), 32'd0);
        fork
            check_frame(16'h2733, 1'b0, "b2b_first");
            begin
                repeat (8) @(negedge clk);
                word_in = 16'h3327;
                word_done = 1'b1;
                repeat (3) @(negedge clk);
                check("b2b_cnt_b1", 32'(fifo_count), 32'd1);
                word_done = 1'b0;
            end
        join
        check("b2b_idle_count", 32'(fifo_count), 32'd1);
        @(negedge clk);
        check("b2b_second_start", 32'(tx_serial), 32'd0);
        check("b2b_second_busy", 32'(tx_busy), 32'd1);
        check("b2b_cnt_b0", 32'(fifo_count), 32'd0);
        check_frame(16'h3327, 1'b0, "b2b_second");

        // Overflow, clear, set-wins, then reset during DATA bit 7 of the first frame.
        do_reset();
        push_fast(16'h2733);
        check("ovf_start", 32'(tx_serial), 32'd0);
        push_fast(16'h1111);
        push_fast(16'h2222);
        push_fast(16'h3333);
        push_fast(16'h4444);
        push_fast(16'h5555);
        repeat (4) @(negedge clk);
        check("ovf_count", 32'(fifo_count), 32'd4);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_busy", 32'(tx_busy), 32'd1);
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);
        word_in = 16'h6666;
        word_done = 1'b1;
        repeat (2) @(negedge clk);
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        word_done = 1'b0;
        check("ovf_set_wins", 32'(overflow), 32'd1);
        check("ovf_count_kept", 32'(fifo_count), 32'd4);
        repeat (5) @(negedge clk);
        check("mid_bit7_tx", 32'(tx_serial), 32'd0);
        check("mid_bit7_busy", 32'(tx_busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_tx", 32'(tx_serial), 32'd1);
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        check("mid_rst_busy", 32'(tx_busy), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_serial !== 1'b1 || tx_busy !== 1'b0) lows++;
        end
        check("mid_rst_quiet", lows, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/otp_tx_serializer.md
# otp_tx_serializer

Downstream stage of `otp_encryption_decryption`. Captures each 16-bit result word when that block raises `done`, buffers it in a small FIFO, and transmits it on a single serial line as a framed word: start bit, 16 data bits LSB first, optional even-parity bit, and stop bit. This decouples the encrypt/decrypt core's completion timing from the fixed-rate link that carries ciphertext off-chip.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; legal range ≥2.
- `FIFO_DEPTH`, default 4: word buffer depth; power of two, ≥2.
- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `word_in`  in  16  result word; connects to `output_data` of the OTP core. Must be stable while `word_done` is high.
- `word_done`  in  1  connects to `done` of the OTP core. Level signal, not necessarily synchronous to `clk`.
- `clear_overflow`  in  1  one-cycle pulse that clears `overflow`.
- `tx_serial`  out  1  serial line; idles high.
- `tx_busy`  out  1  high while a frame is being sent (all non-IDLE states).
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  words currently buffered.
- `overflow`  out  1  sticky flag set when a word is dropped because the FIFO is full.

## Operation
- **Capture**
  - `word_done` passes through a 2-flop synchronizer (`s1`, `s2`) and then a delay flop `s3`.
  - `push = s2 & ~s3`, so exactly one push occurs per rising edge of `word_done`, regardless of how long it stays high.
  - `word_in` is written into the FIFO on the push edge.
- **FIFO**: circular buffer with read and write pointers that wrap at `FIFO_DEPTH`.
  - Push and pop in the same cycle: both take effect and `fifo_count` is unchanged. This holds even when full, so the word is accepted.
  - Push while full with no pop: the word is dropped and `overflow` is set.
  - Pop while empty: never happens; the FSM gates it.
  - `overflow` set and `clear_overflow` in the same cycle: set wins.
- **FSM states**: IDLE, START, DATA, PARITY, STOP.
  - IDLE: `tx_serial` = 1. If `fifo_count` ≠ 0, pop the head word into a 16-bit shift register and go to START.
  - START: `tx_serial` = 0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: `tx_serial` = shift register bit 0. Shift right every `CLKS_PER_BIT` cycles. After 16 bits, go to PARITY if parity is compiled in, otherwise STOP.
  - PARITY: `tx_serial` = XOR of the 16 data bits (even parity) for `CLKS_PER_BIT` cycles, then go to STOP.
  - STOP: `tx_serial` = 1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- **Counters**
  - Bit-time counter runs 0..`CLKS_PER_BIT`-1 and is reset on every state entry.
  - Bit index counter runs 0..15.
- `tx_serial` is driven from a register, so it is glitch-free.

## Timing
- **Reset values**: `tx_serial`=1, `tx_busy`=0, `fifo_count`=0, `overflow`=0. FSM = IDLE; pointers, synchronizer flops and counters = 0.
- **Reset mid-frame**: the frame is aborted, `tx_serial` is 1 from the next edge, and buffered words are discarded.
- **Capture latency**:
  - `word_done` is first sampled high at edge k.
  - Push occurs at edge k+2; `fifo_count` updates after edge k+2.
- **Start latency**: if the FSM is IDLE with the FIFO empty, the pop happens at edge k+3. `tx_serial` falls and `tx_busy` rises after edge k+3.
- **Frame length**: (18+P)·`CLKS_PER_BIT` cycles, where P=1 with parity and P=0 without.
- **Back-to-back frames**: exactly one IDLE cycle with `tx_serial`=1 between the stop bit and the next start bit.
- **Minimum `word_done` pulse**: high for ≥2 `clk` periods, and low for ≥2 periods between words.

## Configuration
- Macro: `OTP_TX_PARITY_EN`.
- Defined: the PARITY state is present. Frame = 19 bits, with even parity over the 16 data bits.
- Undefined: the PARITY state and parity logic are removed. DATA goes directly to STOP, and frame = 18 bits.

## Test plan
- **Reset**: after reset, `tx_serial`=1, `fifo_count`=0, `overflow`=0, `tx_busy`=0. Line stays idle for 100 cycles with no input.
- **Single word**: `CLKS_PER_BIT`=4, parity on, `word_in`=16'h2733 with a `word_done` pulse.
  - Line sequence: 0, then 1,1,0,0,1,1,0,0,1,1,1,0,0,1,0,0, then parity 0, then 1.
  - Each bit lasts 4 cycles; first 0 appears 3 edges after `word_done` is sampled; 76 busy cycles total.
- **Parity values**: 16'hDEAD gives parity bit 1; 16'h0001 gives parity bit 1. With `OTP_TX_PARITY_EN` undefined, 16'hDEAD gives an 18-bit frame of 72 cycles.
- **Back-to-back**: push 16'h2733 then 16'h3327 while the first frame is in flight.
  - Second start bit follows the first stop bit after exactly one idle cycle.
  - `fifo_count` goes 1→0→1→0.
- **Overflow**: `FIFO_DEPTH`=4, push 6 words during one frame.
  - One word popped, 4 buffered, 1 dropped, `overflow`=1.
  - `clear_overflow` pulse clears it; a simultaneous drop keeps it at 1.
- **Reset mid-frame**: assert `reset` during DATA bit 7. `tx_serial`=1 and `fifo_count`=0 from the next edge; nothing is transmitted afterward.
